// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and load writebacks onto one register-file
// write port, alternating priority on ties, with an optional busy scoreboard.
// Ports: clk, rst (async, active-high)
//   alu_valid/alu_dest/alu_data -> alu_ready   ALU writeback request
//   mem_valid/mem_dest/mem_data -> mem_ready   load writeback request
//   issue_valid/issue_dest                     marks a destination pending
//   src1/src2 -> src1_busy/src2_busy, stall    operand hazard query
//   rf_write_enable, rf_dest, rf_alu_data,
//   rf_memory_in, rf_mem_data_in               registered write port
// Config: define WB_SCOREBOARD_EN to build the busy scoreboard; when it is
//   undefined, busy/stall are tied low and the issue inputs are ignored.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_dest,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dest,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    output logic        src1_busy,
    output logic        src2_busy,
    output logic        rf_write_enable,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_alu_data,
    output logic [31:0] rf_memory_in,
    output logic        rf_mem_data_in,
    output logic        stall
);

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        grant_alu, grant_mem;
    logic        wen_q, wen_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mem_q, mem_d;
    logic        sel_q, sel_d;

    // Grants are held off while reset is asserted so nothing is accepted
    // that the reset would then throw away.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        state_d   = state_q;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                if (state_q == PRI_ALU) begin
                    grant_alu = 1'b1;
                    state_d   = PRI_MEM;
                end else begin
                    grant_mem = 1'b1;
                    state_d   = PRI_ALU;
                end
            end else begin
                grant_alu = alu_valid;
                grant_mem = mem_valid;
            end
        end
    end

    always_comb begin
        wen_d  = grant_alu | grant_mem;
        dest_d = dest_q;
        alu_d  = alu_q;
        mem_d  = mem_q;
        sel_d  = sel_q;
        if (grant_alu) begin
            dest_d = alu_dest;
            alu_d  = alu_data;
            sel_d  = 1'b0;
        end else if (grant_mem) begin
            dest_d = mem_dest;
            mem_d  = mem_data;
            sel_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRI_ALU;
            wen_q   <= 1'b0;
            dest_q  <= 5'd0;
            alu_q   <= 32'd0;
            mem_q   <= 32'd0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            dest_q  <= dest_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            sel_q   <= sel_d;
        end
    end

    assign alu_ready       = grant_alu;
    assign mem_ready       = grant_mem;
    assign rf_write_enable = wen_q;
    assign rf_dest         = dest_q;
    assign rf_alu_data     = alu_q;
    assign rf_memory_in    = mem_q;
    assign rf_mem_data_in  = sel_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // A bit clears on the edge that launches its write; a same-edge issue
    // to that index is applied last so the newer producer keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wen_d) begin
            busy_d[dest_d] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign src1_busy = busy_q[src1];
    assign src2_busy = busy_q[src2];
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_dest, src1, src2};
    assign src1_busy    = 1'b0;
    assign src2_busy    = 1'b0;
`endif

    assign stall = src1_busy | src2_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of regfile_wb_arbiter
// against a cycle-level reference model of arbitration and scoreboard.
module tb_regfile_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_dest = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_dest = 5'd0;
    logic [31:0] mem_data = 32'd0;
    logic        mem_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_dest = 5'd0;
    logic [4:0]  src1 = 5'd0;
    logic [4:0]  src2 = 5'd0;
    logic        src1_busy, src2_busy;
    logic        rf_write_enable;
    logic [4:0]  rf_dest;
    logic [31:0] rf_alu_data;
    logic [31:0] rf_memory_in;
    logic        rf_mem_data_in;
    logic        stall;

    int n_chk = 0;
    int n_fail = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest),
        .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dest(mem_dest),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .src1(src1), .src2(src2),
        .src1_busy(src1_busy), .src2_busy(src2_busy),
        .rf_write_enable(rf_write_enable), .rf_dest(rf_dest),
        .rf_alu_data(rf_alu_data), .rf_memory_in(rf_memory_in),
        .rf_mem_data_in(rf_mem_data_in), .stall(stall)
    );

    always #5 clk = ~clk;

    // Reference model: who wins a tie, which registers are pending,
    // and what the write port should show after the next edge.
    bit          m_alu_first;
    bit [31:0]   m_busy;
    bit          m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_alu, m_mem;
    bit          m_sel;

    function automatic void model_reset();
        m_alu_first = 1'b1;
        m_busy = '0;
        m_we = 1'b0;
        m_dest = 5'd0;
        m_alu = 32'd0;
        m_mem = 32'd0;
        m_sel = 1'b0;
    endfunction

    function automatic void model_grant(output bit ga, output bit gm);
        ga = 1'b0;
        gm = 1'b0;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                ga = m_alu_first;
                gm = !m_alu_first;
            end else begin
                ga = alu_valid;
                gm = mem_valid;
            end
        end
    endfunction

    function automatic void model_edge();
        bit ga, gm;
        model_grant(ga, gm);
        m_we = ga | gm;
        if (ga) begin
            m_dest = alu_dest;
            m_alu = alu_data;
            m_sel = 1'b0;
        end
        if (gm) begin
            m_dest = mem_dest;
            m_mem = mem_data;
            m_sel = 1'b1;
        end
        if (ga | gm) m_busy[m_dest] = 1'b0;
        if (issue_valid) m_busy[issue_dest] = 1'b1;
        if (!rst && alu_valid && mem_valid) m_alu_first = !m_alu_first;
    endfunction

    // Advance one cycle; inputs stay stable from here until the next call.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #1 rst = 1'b1;
        model_reset();
        #1;
        n_chk++;
        if ({rf_write_enable, rf_dest, rf_alu_data, rf_memory_in,
             rf_mem_data_in} !== 71'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got %0h want 0",
                     {rf_write_enable, rf_dest, rf_alu_data,
                      rf_memory_in, rf_mem_data_in});
        end
        @(posedge clk);
        #1;
        n_chk++;
        if ({alu_ready, mem_ready, stall, rf_write_enable} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0000",
                     {alu_ready, mem_ready, stall, rf_write_enable});
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1;
        alu_dest = 5'd3;
        alu_data = 32'hDEADBEEF;
        #1;
        n_chk++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL alu_ready: got %b want 10",
                     {alu_ready, mem_ready});
        end
        step();
        alu_valid = 1'b0;
        n_chk++;
        if ({rf_write_enable, rf_dest, rf_alu_data, rf_mem_data_in} !==
            {1'b1, 5'd3, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_write: got %0h want %0h",
                     {rf_write_enable, rf_dest, rf_alu_data, rf_mem_data_in},
                     {1'b1, 5'd3, 32'hDEADBEEF, 1'b0});
        end
        step();
        n_chk++;
        if ({rf_write_enable, rf_dest, rf_alu_data, rf_memory_in,
             rf_mem_data_in} !== {1'b0, 5'd3, 32'hDEADBEEF, 32'd0, 1'b0})
        begin
            n_fail++;
            $display("FAIL idle_hold: we=%b dest=%0d alu=%h mem=%h sel=%b",
                     rf_write_enable, rf_dest, rf_alu_data,
                     rf_memory_in, rf_mem_data_in);
        end
    endtask

    task automatic test_single_mem();
        mem_valid = 1'b1;
        mem_dest = 5'd12;
        mem_data = 32'h12345678;
        #1;
        n_chk++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL mem_ready: got %b want 01",
                     {alu_ready, mem_ready});
        end
        step();
        mem_valid = 1'b0;
        n_chk++;
        if ({rf_write_enable, rf_dest, rf_alu_data, rf_memory_in,
             rf_mem_data_in} !==
            {1'b1, 5'd12, 32'hDEADBEEF, 32'h12345678, 1'b1}) begin
            n_fail++;
            $display("FAIL mem_write: we=%b dest=%0d alu=%h mem=%h sel=%b",
                     rf_write_enable, rf_dest, rf_alu_data,
                     rf_memory_in, rf_mem_data_in);
        end
    endtask

    task automatic test_tie_alternation();
        bit [3:0] pat = 4'b0101;
        bit ga, gm;
        alu_valid = 1'b1;
        alu_dest = 5'd1;
        alu_data = 32'hA000_0000;
        mem_valid = 1'b1;
        mem_dest = 5'd2;
        mem_data = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++;
            if ({alu_ready, mem_ready} !== {pat[i], !pat[i]}) begin
                n_fail++;
                $display("FAIL tie_grant[%0d]: got %b want %b", i,
                         {alu_ready, mem_ready}, {pat[i], !pat[i]});
            end
            model_grant(ga, gm);
            step();
            n_chk++;
            if ({rf_write_enable, rf_dest, rf_alu_data, rf_memory_in,
                 rf_mem_data_in} !== {m_we, m_dest, m_alu, m_mem, m_sel})
            begin
                n_fail++;
                $display("FAIL tie_write[%0d]: got dest=%0d sel=%b want %0d %b",
                         i, rf_dest, rf_mem_data_in, m_dest, m_sel);
            end
            if (ga) alu_data = alu_data + 32'd1;
            if (gm) mem_data = mem_data + 32'd1;
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic test_hazard();
        issue_valid = 1'b1;
        issue_dest = 5'd7;
        src1 = 5'd7;
        src2 = 5'd30;
        #1;
        n_chk++;
        if ({src1_busy, stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL hazard_pre: got %b want 00", {src1_busy, stall});
        end
        step();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if ({src1_busy, src2_busy, stall} !== {SB, 1'b0, SB}) begin
                n_fail++;
                $display("FAIL hazard_wait[%0d]: got %b want %b", i,
                         {src1_busy, src2_busy, stall}, {SB, 1'b0, SB});
            end
            step();
        end
        mem_valid = 1'b1;
        mem_dest = 5'd7;
        mem_data = 32'h0000_0777;
        #1;
        n_chk++;
        if ({src1_busy, stall} !== {SB, SB}) begin
            n_fail++;
            $display("FAIL hazard_grant: got %b want %b",
                     {src1_busy, stall}, {SB, SB});
        end
        step();
        mem_valid = 1'b0;
        #1;
        n_chk++;
        if ({src1_busy, stall, rf_write_enable, rf_dest, rf_mem_data_in}
            !== {1'b0, 1'b0, 1'b1, 5'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL hazard_commit: busy=%b stall=%b we=%b dest=%0d",
                     src1_busy, stall, rf_write_enable, rf_dest);
        end
    endtask

    task automatic test_same_cycle_set();
        src2 = 5'd20;
        issue_valid = 1'b1;
        issue_dest = 5'd20;
        step();
        alu_valid = 1'b1;
        alu_dest = 5'd20;
        alu_data = 32'h2020_2020;
        step();
        alu_valid = 1'b0;
        #1;
        n_chk++;
        if ({src2_busy, rf_write_enable, rf_dest} !== {SB, 1'b1, 5'd20}) begin
            n_fail++;
            $display("FAIL set_wins_grant: busy=%b we=%b dest=%0d want %b 1 20",
                     src2_busy, rf_write_enable, rf_dest, SB);
        end
        step();
        issue_valid = 1'b0;
        #1;
        n_chk++;
        if (src2_busy !== SB) begin
            n_fail++;
            $display("FAIL set_wins_commit: got %b want %b", src2_busy, SB);
        end
        mem_valid = 1'b1;
        mem_dest = 5'd20;
        mem_data = 32'h0000_2021;
        step();
        mem_valid = 1'b0;
        #1;
        n_chk++;
        if (src2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_20: got %b want 0", src2_busy);
        end
    endtask

    task automatic test_nonbusy_and_reg0();
        src1 = 5'd5;
        src2 = 5'd0;
        alu_valid = 1'b1;
        alu_dest = 5'd5;
        alu_data = 32'h5555_5555;
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1;
        issue_dest = 5'd0;
        step();
        issue_valid = 1'b0;
        #1;
        n_chk++;
        if ({src1_busy, src2_busy} !== {1'b0, SB}) begin
            n_fail++;
            $display("FAIL nonbusy_reg0: got %b want %b",
                     {src1_busy, src2_busy}, {1'b0, SB});
        end
        alu_valid = 1'b1;
        alu_dest = 5'd0;
        alu_data = 32'h0000_0001;
        step();
        alu_valid = 1'b0;
        #1;
        n_chk++;
        if ({src2_busy, rf_dest, rf_alu_data} !== {1'b0, 5'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL reg0_commit: busy=%b dest=%0d data=%h",
                     src2_busy, rf_dest, rf_alu_data);
        end
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1;
        alu_dest = 5'd9;
        alu_data = 32'hAAAA_0009;
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b1;
        mem_dest = 5'd9;
        mem_data = 32'hBBBB_0009;
        n_chk++;
        if ({rf_write_enable, rf_dest, rf_alu_data, rf_mem_data_in} !==
            {1'b1, 5'd9, 32'hAAAA_0009, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_first: dest=%0d alu=%h sel=%b",
                     rf_dest, rf_alu_data, rf_mem_data_in);
        end
        step();
        mem_valid = 1'b0;
        n_chk++;
        if ({rf_write_enable, rf_dest, rf_memory_in, rf_mem_data_in} !==
            {1'b1, 5'd9, 32'hBBBB_0009, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second: dest=%0d mem=%h sel=%b",
                     rf_dest, rf_memory_in, rf_mem_data_in);
        end
    endtask

    task automatic test_random();
        bit ga = 1'b0;
        bit gm = 1'b0;
        bit [2:0] want;
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid || ga) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_dest = 5'($urandom_range(0, 7));
                alu_data = $urandom;
            end
            if (!mem_valid || gm) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_dest = 5'($urandom_range(0, 7));
                mem_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_dest = 5'($urandom_range(0, 7));
            src1 = 5'($urandom_range(0, 7));
            src2 = 5'($urandom_range(0, 7));
            #1;
            model_grant(ga, gm);
            n_chk++;
            if ({alu_ready, mem_ready} !== {ga, gm}) begin
                n_fail++;
                $display("FAIL rand_grant[%0d]: got %b want %b", c,
                         {alu_ready, mem_ready}, {ga, gm});
            end
            want = {SB & m_busy[src1], SB & m_busy[src2],
                    SB & (m_busy[src1] | m_busy[src2])};
            n_chk++;
            if ({src1_busy, src2_busy, stall} !== want) begin
                n_fail++;
                $display("FAIL rand_busy[%0d]: got %b want %b", c,
                         {src1_busy, src2_busy, stall}, want);
            end
            step();
            n_chk++;
            if ({rf_write_enable, rf_dest, rf_alu_data, rf_memory_in,
                 rf_mem_data_in} !== {m_we, m_dest, m_alu, m_mem, m_sel})
            begin
                n_fail++;
                $display("FAIL rand_write[%0d]: got %0h want %0h", c,
                         {rf_write_enable, rf_dest, rf_alu_data,
                          rf_memory_in, rf_mem_data_in},
                         {m_we, m_dest, m_alu, m_mem, m_sel});
            end
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        issue_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_midstream();
        issue_valid = 1'b1;
        issue_dest = 5'd4;
        src1 = 5'd4;
        alu_valid = 1'b1;
        alu_dest = 5'd11;
        alu_data = 32'h1111_1111;
        mem_valid = 1'b1;
        mem_dest = 5'd12;
        mem_data = 32'h2222_2222;
        step();
        issue_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({rf_write_enable, rf_dest, rf_alu_data, rf_memory_in,
             rf_mem_data_in, alu_ready, mem_ready, src1_busy, stall}
            !== 75'd0) begin
            n_fail++;
            $display("FAIL midreset_async: we=%b dest=%0d rdy=%b busy=%b",
                     rf_write_enable, rf_dest, {alu_ready, mem_ready},
                     src1_busy);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if ({rf_write_enable, rf_alu_data, rf_memory_in} !== 65'd0) begin
            n_fail++;
            $display("FAIL midreset_hold: we=%b alu=%h mem=%h",
                     rf_write_enable, rf_alu_data, rf_memory_in);
        end
        rst = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_tie: got %b want 10",
                     {alu_ready, mem_ready});
        end
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        n_chk++;
        if ({rf_write_enable, rf_dest, rf_alu_data, rf_mem_data_in} !==
            {1'b1, 5'd11, 32'h1111_1111, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_write: dest=%0d alu=%h sel=%b",
                     rf_dest, rf_alu_data, rf_mem_data_in);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_single_mem();
        test_tie_alternation();
        test_hazard();
        test_same_cycle_set();
        test_nonbusy_and_reg0();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 clk  input  1  Single clock; all state changes on its rising edge.
REQ-002 rst  input  1  Asynchronous reset, active-high.
REQ-003 alu_valid  input  1  ALU writeback request.
REQ-004 alu_dest  input  5  ALU destination register.
REQ-005 alu_data  input  32  ALU result.
REQ-006 alu_ready  output  1  ALU request accepted this cycle (combinational).
REQ-007 mem_valid  input  1  Load writeback request.
REQ-008 mem_dest  input  5  Load destination register.
REQ-009 mem_data  input  32  Load data.
REQ-010 mem_ready  output  1  Load request accepted this cycle (combinational).
REQ-011 issue_valid  input  1  An instruction with a destination issues; marks issue_dest pending.
REQ-012 issue_dest  input  5  Destination of the issuing instruction.
REQ-013 src1, src2  input  5 each  Operand indices queried for hazards.
REQ-014 src1_busy, src2_busy  output  1 each  Queried register has a pending write (combinational).
REQ-015 rf_write_enable  output  1  Register-file write strobe (registered).
REQ-016 rf_dest  output  5  Register-file write index (registered).
REQ-017 rf_alu_data  output  32  Data to the register file ALU input (registered).
REQ-018 rf_memory_in  output  32  Data to the register file memory input (registered).
REQ-019 rf_mem_data_in  output  1  Register-file source select: 1 = memory, 0 = ALU (registered).
REQ-020 stall  output  1  src1_busy OR src2_busy.

Function
REQ-021 Arbiter FSM states: PRI_ALU (ALU wins a tie), PRI_MEM (memory wins a tie); reset state PRI_ALU.
REQ-022 Only one valid: that requester granted regardless of state.
REQ-023 Both valid: state-preferred requester granted; FSM moves to the other state on that edge.
REQ-024 Single grant or no request: FSM state unchanged.
REQ-025 *_ready high only in the cycle its request is granted; never both high.
REQ-026 Handshake = valid & ready; ungranted requester holds valid, dest, data stable until granted.
REQ-027 Latency: a grant in cycle N drives rf_write_enable=1 with matching rf_dest, data and rf_mem_data_in in cycle N+1.
REQ-028 With no grant in cycle N, rf_write_enable=0 in cycle N+1; rf_dest, rf_alu_data, rf_memory_in and rf_mem_data_in hold their previous values.
REQ-029 ALU grant loads rf_alu_data and sets rf_mem_data_in=0; memory grant loads rf_memory_in and sets rf_mem_data_in=1; the unselected data register holds.
REQ-030 Scoreboard: a 32-bit busy vector. Bit set on issue_valid; bit cleared on the edge that asserts rf_write_enable for that index.
REQ-031 Same-cycle issue and commit to one index: set wins and the bit stays busy.
REQ-032 Commit to a non-busy index is legal; the bit stays 0.
REQ-033 All 32 indices are treated identically, including register 0.
REQ-034 Same dest from both requesters on consecutive grants: the later grant writes last, and both writes reach the register file in grant order.

Reset
REQ-035 rst=1 forces FSM=PRI_ALU, busy vector=0, rf_write_enable=0, rf_dest=0, rf_alu_data=0, rf_memory_in=0, rf_mem_data_in=0, immediately and without waiting for clk.
REQ-036 A grant issued in the cycle reset asserts is discarded and produces no write.
REQ-037 While rst=1, alu_ready=mem_ready=0.
REQ-038 The first grant is possible in the first cycle after deassertion.

Configuration
REQ-039 Macro WB_SCOREBOARD_EN defined: the scoreboard operates per REQ-030..REQ-032.
REQ-040 Macro WB_SCOREBOARD_EN undefined: no busy storage; src1_busy, src2_busy and stall are tied to 0; issue inputs are ignored; arbitration is unchanged.

Verification
REQ-041 Reset, then alu_valid only, dest=3, data=0xDEADBEEF -> alu_ready=1 that cycle; next cycle rf_write_enable=1, rf_dest=3, rf_alu_data=0xDEADBEEF, rf_mem_data_in=0.
REQ-042 Both valid for 4 cycles, held per handshake -> grants ALU, MEM, ALU, MEM; never both ready.
REQ-043 issue dest=7, src1=7 -> src1_busy=1 and stall=1 until the cycle after the mem write to 7 commits.
REQ-044 issue dest=20 in the same cycle rf_write_enable=1 with rf_dest=20 -> busy[20] stays 1.
REQ-045 Assert rst mid-stream with both valid and busy bits set -> outputs zero asynchronously, busy cleared, next tie granted to ALU.
REQ-046 Build without WB_SCOREBOARD_EN, issue dest=7 and query src1=7 -> src1_busy=0; writes identical to REQ-041.
